// File: rtl/scan_chain_driver_if.sv
// Handshake and scan-chain signal bundle between a transaction requester,
// the scan chain driver and the physical scan_flop/latch chain.
interface scan_chain_driver_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] din;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic         scan_clk;
  logic         scan_select;
  logic         scan_data_out;
  logic         scan_data_in;
  logic         scan_latch_en;

  modport master (
    input  start, din, scan_data_in,
    output busy, done, dout, scan_clk, scan_select, scan_data_out, scan_latch_en
  );

  modport slave (
    output start, din, scan_data_in,
    input  busy, done, dout, scan_clk, scan_select, scan_data_out, scan_latch_en
  );
endinterface

// File: rtl/scan_chain_driver.sv
// Capture / shift / latch sequencer for a 2W-long scan chain: the first W flops
// feed the design inputs through latches, the last W flops capture its outputs.
module scan_chain_driver #(
  parameter int W       = 8,
  parameter int HALF    = 2,
  parameter int LATCH_N = 2
) (
  input logic                  clk,
  input logic                  reset,
  scan_chain_driver_if.master  bus
);
  localparam int CW = $clog2(2 * W + 1);
  localparam int PW = $clog2(3 * HALF + 1);
  localparam int LW = $clog2(LATCH_N + 1);

  localparam logic [PW-1:0] PH_RISE    = PW'(HALF - 1);
  localparam logic [PW-1:0] PH_FALL    = PW'(2 * HALF - 1);
  localparam logic [PW-1:0] PH_CAP_END = PW'(3 * HALF - 1);
  localparam logic [CW-1:0] K_OUT_END  = CW'(W - 1);
  localparam logic [CW-1:0] K_LAST     = CW'(2 * W - 1);
  localparam logic [LW-1:0] L_END      = LW'(LATCH_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [CW-1:0] shift_q;
  logic [LW-1:0] lcnt_q;
  logic [W-1:0]  din_sh_q;
  logic [W-1:0]  shadow_q;
  logic [W-1:0]  dout_q;
  logic          busy_q;
  logic          done_q;
  logic          sclk_q;
  logic          ssel_q;
  logic          sdo_q;
  logic          sle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      shift_q  <= '0;
      lcnt_q   <= '0;
      din_sh_q <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      ssel_q   <= 1'b0;
      sdo_q    <= 1'b0;
      sle_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_CAPTURE;
            din_sh_q <= bus.din;
            busy_q   <= 1'b1;
            phase_q  <= '0;
          end
        end
        S_CAPTURE: begin
          if (phase_q == PH_CAP_END) begin
            state_q <= S_SHIFT;
            phase_q <= '0;
            shift_q <= '0;
            ssel_q  <= 1'b1;
            sdo_q   <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
            if (phase_q == PH_RISE) sclk_q <= 1'b1;
            if (phase_q == PH_FALL) sclk_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          // The chain tail still holds the pre-shift bit on the edge that raises scan_clk.
          if (phase_q == PH_RISE) begin
            sclk_q <= 1'b1;
            if (shift_q <= K_OUT_END) shadow_q <= {shadow_q[W-2:0], bus.scan_data_in};
          end
          if (phase_q == PH_FALL) begin
            sclk_q  <= 1'b0;
            phase_q <= '0;
            if (shift_q == K_LAST) begin
              state_q <= S_LATCH;
              ssel_q  <= 1'b0;
              sdo_q   <= 1'b0;
              sle_q   <= 1'b1;
              lcnt_q  <= '0;
            end else begin
              shift_q <= shift_q + 1'b1;
              // Zeros fill the output half first, then din goes in MSB first.
              if (shift_q >= K_OUT_END) begin
                sdo_q    <= din_sh_q[W-1];
                din_sh_q <= {din_sh_q[W-2:0], 1'b0};
              end
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_LATCH: begin
          if (lcnt_q == L_END) begin
            sle_q   <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            dout_q  <= shadow_q;
            busy_q  <= 1'b0;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.dout          = dout_q;
  assign bus.scan_clk      = sclk_q;
  assign bus.scan_select   = ssel_q;
  assign bus.scan_data_out = sdo_q;
  assign bus.scan_latch_en = sle_q;
endmodule

// File: tb/tb_scan_chain_driver.sv
// Three drivers (HALF = 1, 2, 3), each closing the loop through a scan chain of
// 2W flops and W latches whose design function is out = in + 1.
module tb_scan_chain_driver;
  localparam int W       = 8;
  localparam int LATCH_N = 2;
  localparam int NI      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         start_a    [NI];
  logic [W-1:0] din_a      [NI];
  logic         busy_a     [NI];
  logic         done_a     [NI];
  logic [W-1:0] dout_a     [NI];
  logic         sclk_a     [NI];
  logic         ssel_a     [NI];
  logic         sdo_a      [NI];
  logic         sle_a      [NI];
  logic [W-1:0] latch_a    [NI];
  int           rise_a     [NI];
  int           dones_a    [NI];
  int           stab_v_a   [NI];
  int           ovl_v_a    [NI];

  logic [W-1:0] model_latch [NI];
  int n_chk  = 0;
  int n_fail = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int H = gi + 1;
    scan_chain_driver_if #(.W(W)) bus ();
    logic [2*W-1:0] chain = '0;
    logic [W-1:0]   latch = '0;
    logic           sclk_p = 1'b0;
    logic           sdo_p = 1'b0;
    int             stab = 0;
    int             rises = 0;
    int             dones = 0;
    int             sv = 0;
    int             ov = 0;

    assign bus.start        = start_a[gi];
    assign bus.din          = din_a[gi];
    assign bus.scan_data_in = chain[2*W-1];

    scan_chain_driver #(.W(W), .HALF(H), .LATCH_N(LATCH_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Capture fills the input flops with junk and the output flops with latch + 1.
    always @(posedge bus.scan_clk) begin
      if (bus.scan_select) chain <= {chain[2*W-2:0], bus.scan_data_out};
      else                 chain <= {W'(latch + 1'b1), W'($urandom)};
    end

    always @(negedge clk) begin
      if (bus.scan_latch_en) latch <= chain[W-1:0];
      if ((bus.scan_data_out != sdo_p) && bus.scan_clk) sv <= sv + 1;
      if (bus.scan_clk && !sclk_p && bus.scan_select && (stab < H - 1)) sv <= sv + 1;
      if (bus.scan_latch_en && (bus.scan_clk || bus.scan_select)) ov <= ov + 1;
      if (bus.scan_clk && !sclk_p) rises <= rises + 1;
      if (bus.done) dones <= dones + 1;
      stab   <= (bus.scan_data_out != sdo_p) ? 0 : ((stab < 1000) ? stab + 1 : stab);
      sdo_p  <= bus.scan_data_out;
      sclk_p <= bus.scan_clk;
    end

    assign busy_a[gi]   = bus.busy;
    assign done_a[gi]   = bus.done;
    assign dout_a[gi]   = bus.dout;
    assign sclk_a[gi]   = bus.scan_clk;
    assign ssel_a[gi]   = bus.scan_select;
    assign sdo_a[gi]    = bus.scan_data_out;
    assign sle_a[gi]    = bus.scan_latch_en;
    assign latch_a[gi]  = latch;
    assign rise_a[gi]   = rises;
    assign dones_a[gi]  = dones;
    assign stab_v_a[gi] = sv;
    assign ovl_v_a[gi]  = ov;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int txn_len(input int g);
    return 1 + (3 + 4 * W) * (g + 1) + LATCH_N + 1;
  endfunction

  task automatic run_txn(input int g, input logic [W-1:0] d);
    int cnt;
    int r0, d0, s0, o0;
    logic seen;
    logic [W-1:0] exp_dout;
    exp_dout = model_latch[g] + 8'd1;
    tick();
    chk("idle_before", busy_a[g], 1'b0);
    r0 = rise_a[g]; d0 = dones_a[g]; s0 = stab_v_a[g]; o0 = ovl_v_a[g];
    start_a[g] = 1'b1;
    din_a[g]   = d;
    tick();
    start_a[g] = 1'b0;
    din_a[g]   = W'($urandom);
    cnt = 1;
    chk("busy_after_start", busy_a[g], 1'b1);
    seen = 1'b0;
    while (!seen && cnt < 1000) begin
      if (done_a[g]) seen = 1'b1;
      else begin
        tick();
        cnt++;
        if ($urandom_range(3) == 0) din_a[g] = W'($urandom);
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("txn_len", cnt + 1, txn_len(g));
    chk("dout", dout_a[g], exp_dout);
    chk("latch", latch_a[g], d);
    chk("scan_clk_rises", rise_a[g] - r0, 2 * W + 1);
    chk("done_pulses", dones_a[g] - d0, 1);
    chk("sdo_stability", stab_v_a[g] - s0, 0);
    chk("latch_overlap", ovl_v_a[g] - o0, 0);
    $display("txn inst=%0d half=%0d din=%02h dout=%02h latch=%02h len=%0d",
             g, g + 1, d, dout_a[g], latch_a[g], cnt + 1);
    tick();
    chk("done_one_cycle", done_a[g], 1'b0);
    model_latch[g] = d;
  endtask

  initial begin
    int cnt;
    int d0, r0, len;
    logic [W-1:0] d;
    for (int g = 0; g < NI; g++) begin
      start_a[g] = 1'b0;
      din_a[g] = '0;
      model_latch[g] = '0;
    end
    repeat (3) tick();
    for (int g = 0; g < NI; g++) begin
      chk("rst_busy", busy_a[g], 1'b0);
      chk("rst_done", done_a[g], 1'b0);
      chk("rst_dout", dout_a[g], '0);
      chk("rst_scan_clk", sclk_a[g], 1'b0);
      chk("rst_scan_select", ssel_a[g], 1'b0);
      chk("rst_scan_data_out", sdo_a[g], 1'b0);
      chk("rst_latch_en", sle_a[g], 1'b0);
    end
    reset = 1'b0;

    // Loopback and edge values at HALF=2
    run_txn(1, 8'h5A);
    run_txn(1, 8'h00);
    run_txn(1, 8'hFF);
    run_txn(1, 8'h00);
    for (int i = 0; i < 4; i++) run_txn(1, W'($urandom));

    // Timing at HALF=1 and HALF=3
    for (int i = 0; i < 3; i++) run_txn(0, W'($urandom));
    for (int i = 0; i < 3; i++) run_txn(2, W'($urandom));

    // start held high for 100 cycles
    d = W'($urandom);
    len = txn_len(1);
    tick();
    d0 = dones_a[1]; r0 = rise_a[1];
    start_a[1] = 1'b1;
    din_a[1] = d;
    repeat (100) tick();
    start_a[1] = 1'b0;
    repeat (200) tick();
    chk("hold_done_pulses", dones_a[1] - d0, (100 + len - 1) / len);
    chk("hold_rises", rise_a[1] - r0, ((100 + len - 1) / len) * (2 * W + 1));
    chk("hold_latch", latch_a[1], d);
    chk("hold_dout", dout_a[1], d + 8'd1);
    chk("hold_idle", busy_a[1], 1'b0);
    $display("txn inst=1 half=2 start_held=100 dones=%0d latch=%02h", dones_a[1] - d0, latch_a[1]);
    model_latch[1] = d;

    // Reset in the middle of SHIFT
    tick();
    start_a[1] = 1'b1;
    din_a[1] = 8'hC3;
    tick();
    start_a[1] = 1'b0;
    cnt = 0;
    while (!ssel_a[1] && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("reach_shift", ssel_a[1], 1'b1);
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy_a[1], 1'b0);
    chk("abort_scan_clk", sclk_a[1], 1'b0);
    chk("abort_scan_select", ssel_a[1], 1'b0);
    chk("abort_latch_en", sle_a[1], 1'b0);
    chk("abort_scan_data_out", sdo_a[1], 1'b0);
    chk("abort_dout", dout_a[1], '0);
    $display("txn inst=1 half=2 din=c3 aborted by reset");
    tick();
    reset = 1'b0;
    chk("abort_latch_kept", latch_a[1], model_latch[1]);
    run_txn(1, W'($urandom));

    for (int g = 0; g < NI; g++) begin
      chk("total_sdo_stability", stab_v_a[g], 0);
      chk("total_latch_overlap", ovl_v_a[g], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
